ula_acumulador: RTL and testbench
=================================

ULA_ACUMULADOR -- requirements
Module: ula_acumulador

Interface
REQ-001 Parameter: WIDTH, default 8, data width of MBR, AC, ALU result and memory data.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately, independent of clock.
REQ-004 ula_sel  input  4  ALU operation select from control FSM; 0000 = no selection.
REQ-005 ula_re  input  1  ALU result read/commit strobe.
REQ-006 ac_wr  input  1  accumulator write enable.
REQ-007 ac_re  input  1  accumulator drives bus_out.
REQ-008 mbr_wr_m  input  1  MBR load from data memory (mem_q).
REQ-009 mbr_wr_b  input  1  MBR load from accumulator (store path).
REQ-010 mbr_re_b  input  1  MBR drives bus_out.
REQ-011 mem_q  input  WIDTH  data memory read data.
REQ-012 mem_d  output  WIDTH  data memory write data, equal to MBR.
REQ-013 bus_out  output  WIDTH  internal bus value.
REQ-014 ac_q  output  WIDTH  accumulator contents.
REQ-015 flagz  output  1  zero flag to control FSM.
REQ-016 flagn  output  1  negative flag (AC MSB) to control FSM.
REQ-017 flagc  output  1  carry/borrow/overflow flag of last ALU commit.

Function
REQ-018 Registers: MBR, AC, SEL (4 bits), RES (WIDTH bits), RESC (1 bit), flagz, flagn, flagc.
REQ-019 MBR: mbr_wr_m loads mem_q; else mbr_wr_b loads AC; else hold; mbr_wr_m wins if both.
REQ-020 SEL loads ula_sel on any cycle ula_sel != 0000; holds otherwise, so selection persists across ula_re cycles.
REQ-021 RES/RESC load f(AC, MBR, SEL) on every cycle with ula_re=1; hold otherwise; one-cycle latency from ula_re to RES valid.
REQ-022 f: 0010 AC+MBR, C=carry out; 0011 AC-MBR, C=borrow; 0100 AC*MBR low WIDTH bits, C=1 if upper WIDTH bits nonzero; 0101 AC/MBR (see REQ-032); 0110 AC&MBR; 0111 AC|MBR; 1000 ~AC; any other code AC pass-through; C=0 for all logic/pass ops.
REQ-023 All arithmetic unsigned, WIDTH bits, wrap-around modulo 2^WIDTH.
REQ-024 AC write source when ac_wr=1: RES if ula_re=1 same cycle; else MBR if mbr_re_b=1; else hold AC.
REQ-025 Flags update only on AC write: flagz=(new AC==0), flagn=new AC[WIDTH-1]; flagc=RESC if RES source, else 0.
REQ-026 Thus FSM sequence sel -> ula_re -> ula_re+ac_wr writes the result computed in the first ula_re cycle (RES registered value), no combinational path from ula_sel to AC.
REQ-027 bus_out priority: ula_re -> RES; else mbr_re_b -> MBR; else ac_re -> AC; else all zeros.
REQ-028 mem_d and ac_q are direct register outputs, glitch-free.
REQ-029 ac_wr with none of ula_re/mbr_re_b leaves AC and all flags unchanged.

Reset
REQ-030 While reset=0: MBR, AC, SEL, RES, RESC, flagz, flagn, flagc all 0; bus_out 0 unless a read strobe is active; reset mid-operation discards any pending RES without writing AC.
REQ-031 First rising clock edge with reset=1 resumes normal operation; no extra idle cycle.

Configuration
REQ-032 Macro ULA_DIV_EN: defined -> 0101 gives AC/MBR quotient, C=0; MBR==0 gives all-ones result, C=1; undefined -> divider not instantiated, 0101 treated as AC pass-through, C=0.

Verification
REQ-033 Load: mem_q=0x2A, mbr_wr_m; then mbr_re_b+ac_wr -> AC=0x2A, bus_out=0x2A during read, flagz=0, flagn=0.
REQ-034 Add with carry: AC=0xF0, MBR=0x20, ula_sel=0010, ula_re x2 with ac_wr on 2nd -> AC=0x10, flagc=1, flagz=0.
REQ-035 Sub to zero/negative: AC=0x05, MBR=0x05, sub -> AC=0x00, flagz=1; repeat with MBR=0x06 -> AC=0xFF, flagn=1, flagc=1.
REQ-036 Divide: AC=0x64, MBR=0x07, sel 0101 -> AC=0x0E with ULA_DIV_EN; MBR=0 -> AC=0xFF, flagc=1; without macro AC stays 0x64.
REQ-037 Store path: AC=0x5A, ac_re+mbr_wr_b -> mem_d=0x5A next cycle; simultaneous mbr_wr_m with mem_q=0x11 -> MBR=0x11.
REQ-038 Reset mid-op: after ula_re cycle with RES pending, pull reset low asynchronously between edges -> AC, MBR, flags 0 immediately; after release, ac_wr+ula_re yields RES=0 source only from new computation.

Source files
------------

// File: rtl/ula_acumulador_if.sv
// Bus bundle between the control FSM (master) and the accumulator ALU datapath (slave).
interface ula_acumulador_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       ula_sel;
  logic             ula_re;
  logic             ac_wr;
  logic             ac_re;
  logic             mbr_wr_m;
  logic             mbr_wr_b;
  logic             mbr_re_b;
  logic [WIDTH-1:0] mem_q;
  logic [WIDTH-1:0] mem_d;
  logic [WIDTH-1:0] bus_out;
  logic [WIDTH-1:0] ac_q;
  logic             flagz;
  logic             flagn;
  logic             flagc;

  modport master (
    output ula_sel, ula_re, ac_wr, ac_re, mbr_wr_m, mbr_wr_b, mbr_re_b, mem_q,
    input  mem_d, bus_out, ac_q, flagz, flagn, flagc
  );

  modport slave (
    input  ula_sel, ula_re, ac_wr, ac_re, mbr_wr_m, mbr_wr_b, mbr_re_b, mem_q,
    output mem_d, bus_out, ac_q, flagz, flagn, flagc
  );
endinterface

// File: rtl/ula_acumulador.sv
// Accumulator ALU datapath: MBR, AC, registered op select and registered result with flags.
// Optional divider for op 0101 enabled by defining ULA_DIV_EN.
module ula_acumulador #(
  parameter int WIDTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  ula_acumulador_if.slave   io
);
  logic [WIDTH-1:0] mbr_q, mbr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       sel_q, sel_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             resc_q, resc_d;
  logic             flagz_q, flagz_d;
  logic             flagn_q, flagn_d;
  logic             flagc_q, flagc_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic [WIDTH:0]     wide;
  logic [2*WIDTH-1:0] prod;

  // ALU works only on registered operands and the registered select,
  // so nothing from ula_sel reaches AC combinationally.
  always_comb begin
    alu_res = acc_q;
    alu_c   = 1'b0;
    wide    = '0;
    prod    = '0;
    case (sel_q)
      4'b0010: begin
        wide    = {1'b0, acc_q} + {1'b0, mbr_q};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
      end
      4'b0011: begin
        wide    = {1'b0, acc_q} - {1'b0, mbr_q};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
      end
      4'b0100: begin
        prod    = acc_q * mbr_q;
        alu_res = prod[WIDTH-1:0];
        alu_c   = |prod[2*WIDTH-1:WIDTH];
      end
`ifdef ULA_DIV_EN
      4'b0101: begin
        if (mbr_q == '0) begin
          alu_res = '1;
          alu_c   = 1'b1;
        end else begin
          alu_res = acc_q / mbr_q;
        end
      end
`endif
      4'b0110: alu_res = acc_q & mbr_q;
      4'b0111: alu_res = acc_q | mbr_q;
      4'b1000: alu_res = ~acc_q;
      default: alu_res = acc_q;
    endcase
  end

  always_comb begin
    mbr_d   = mbr_q;
    acc_d   = acc_q;
    sel_d   = sel_q;
    res_d   = res_q;
    resc_d  = resc_q;
    flagz_d = flagz_q;
    flagn_d = flagn_q;
    flagc_d = flagc_q;

    if (io.mbr_wr_m) begin
      mbr_d = io.mem_q;
    end else if (io.mbr_wr_b) begin
      mbr_d = acc_q;
    end

    if (io.ula_sel != 4'b0000) begin
      sel_d = io.ula_sel;
    end

    if (io.ula_re) begin
      res_d  = alu_res;
      resc_d = alu_c;
    end

    // AC takes the previously registered result, not the one being computed now.
    if (io.ac_wr) begin
      if (io.ula_re) begin
        acc_d   = res_q;
        flagz_d = (res_q == '0);
        flagn_d = res_q[WIDTH-1];
        flagc_d = resc_q;
      end else if (io.mbr_re_b) begin
        acc_d   = mbr_q;
        flagz_d = (mbr_q == '0);
        flagn_d = mbr_q[WIDTH-1];
        flagc_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mbr_q   <= '0;
      acc_q   <= '0;
      sel_q   <= 4'b0000;
      res_q   <= '0;
      resc_q  <= 1'b0;
      flagz_q <= 1'b0;
      flagn_q <= 1'b0;
      flagc_q <= 1'b0;
    end else begin
      mbr_q   <= mbr_d;
      acc_q   <= acc_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      resc_q  <= resc_d;
      flagz_q <= flagz_d;
      flagn_q <= flagn_d;
      flagc_q <= flagc_d;
    end
  end

  always_comb begin
    if (io.ula_re) begin
      io.bus_out = res_q;
    end else if (io.mbr_re_b) begin
      io.bus_out = mbr_q;
    end else if (io.ac_re) begin
      io.bus_out = acc_q;
    end else begin
      io.bus_out = '0;
    end
  end

  assign io.mem_d = mbr_q;
  assign io.ac_q  = acc_q;
  assign io.flagz = flagz_q;
  assign io.flagn = flagn_q;
  assign io.flagc = flagc_q;
endmodule

// File: tb/tb_ula_acumulador.sv
// Directed bench for ula_acumulador: table of ALU ops plus hand sequences for load, store, reset.
module tb_ula_acumulador;
  logic clock;
  logic reset;
  int   errors;
  int   checks;

  ula_acumulador_if #(.WIDTH(8)) u_if ();

  ula_acumulador #(.WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .io    (u_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] exp_ac;
    logic       z;
    logic       n;
    logic       c;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%02h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    u_if.ula_sel  = 4'b0000;
    u_if.ula_re   = 1'b0;
    u_if.ac_wr    = 1'b0;
    u_if.ac_re    = 1'b0;
    u_if.mbr_wr_m = 1'b0;
    u_if.mbr_wr_b = 1'b0;
    u_if.mbr_re_b = 1'b0;
  endtask

  task automatic load_mbr(input logic [7:0] v, input logic [3:0] sel);
    idle();
    u_if.mem_q    = v;
    u_if.mbr_wr_m = 1'b1;
    u_if.ula_sel  = sel;
    step();
    idle();
  endtask

  task automatic load_ac(input logic [7:0] v);
    load_mbr(v, 4'b0000);
    u_if.mbr_re_b = 1'b1;
    u_if.ac_wr    = 1'b1;
    step();
    idle();
  endtask

  // sel -> ula_re -> ula_re+ac_wr
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    load_ac(a);
    load_mbr(b, sel);
    u_if.ula_re = 1'b1;
    step();
    u_if.ac_wr = 1'b1;
    step();
    idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    u_if.mem_q = 8'h00;
    idle();

    vecs[0]  = '{8'hF0, 8'h20, 4'b0010, 8'h10, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{8'h01, 8'h02, 4'b0010, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h05, 8'h05, 4'b0011, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'h05, 8'h06, 4'b0011, 8'hFF, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{8'h10, 8'h10, 4'b0100, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{8'h03, 8'h05, 4'b0100, 8'h0F, 1'b0, 1'b0, 1'b0};
`ifdef ULA_DIV_EN
    vecs[6]  = '{8'h64, 8'h07, 4'b0101, 8'h0E, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h64, 8'h00, 4'b0101, 8'hFF, 1'b0, 1'b1, 1'b1};
`else
    vecs[6]  = '{8'h64, 8'h07, 4'b0101, 8'h64, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h64, 8'h00, 4'b0101, 8'h64, 1'b0, 1'b0, 1'b0};
`endif
    vecs[8]  = '{8'hF0, 8'h3C, 4'b0110, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'hF0, 8'h0F, 4'b0111, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{8'h5A, 8'h00, 4'b1000, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{8'h33, 8'h44, 4'b0001, 8'h33, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'h80, 8'h01, 4'b1111, 8'h80, 1'b0, 1'b1, 1'b0};

    reset = 1'b0;
    #12;
    chk("reset_ac", u_if.ac_q, 8'h00);
    chk("reset_mem_d", u_if.mem_d, 8'h00);
    chk("reset_bus", u_if.bus_out, 8'h00);
    chk("reset_flags", {5'b0, u_if.flagz, u_if.flagn, u_if.flagc}, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    step();

    // Load path with bus_out observed during the read
    load_mbr(8'h2A, 4'b0000);
    u_if.mbr_re_b = 1'b1;
    u_if.ac_wr    = 1'b1;
    #1;
    chk("load_bus", u_if.bus_out, 8'h2A);
    step();
    idle();
    chk("load_ac", u_if.ac_q, 8'h2A);
    chk("load_zn", {6'b0, u_if.flagz, u_if.flagn}, 8'h00);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sel);
      $display("vec %0d a=%02h b=%02h sel=%04b", i, vecs[i].a, vecs[i].b, vecs[i].sel);
      chk($sformatf("vec%0d_ac", i), u_if.ac_q, vecs[i].exp_ac);
      chk($sformatf("vec%0d_z", i), {7'b0, u_if.flagz}, {7'b0, vecs[i].z});
      chk($sformatf("vec%0d_n", i), {7'b0, u_if.flagn}, {7'b0, vecs[i].n});
      chk($sformatf("vec%0d_c", i), {7'b0, u_if.flagc}, {7'b0, vecs[i].c});
    end

    // ac_wr alone must not disturb AC or flags (state: AC=FF, n=1, c=1)
    run_op(8'h05, 8'h06, 4'b0011);
    u_if.ac_wr = 1'b1;
    step();
    step();
    idle();
    chk("hold_ac", u_if.ac_q, 8'hFF);
    chk("hold_flags", {5'b0, u_if.flagz, u_if.flagn, u_if.flagc}, 8'h03);

    // bus_out priority: RES over MBR over AC (RES=FF from last commit, MBR=06)
    u_if.ac_re    = 1'b1;
    #1;
    chk("bus_ac", u_if.bus_out, 8'hFF);
    u_if.mbr_re_b = 1'b1;
    #1;
    chk("bus_mbr", u_if.bus_out, 8'h06);
    u_if.ula_sel  = 4'b0000;
    load_mbr(8'h42, 4'b0110);
    u_if.ula_re = 1'b1;
    step();
    u_if.ac_re    = 1'b1;
    u_if.mbr_re_b = 1'b1;
    #1;
    chk("bus_res", u_if.bus_out, 8'h42);
    idle();
    step();

    // Store path, then memory load winning over store
    load_ac(8'h5A);
    u_if.ac_re    = 1'b1;
    u_if.mbr_wr_b = 1'b1;
    #1;
    chk("store_bus", u_if.bus_out, 8'h5A);
    step();
    idle();
    chk("store_mem_d", u_if.mem_d, 8'h5A);
    u_if.mem_q    = 8'h11;
    u_if.mbr_wr_m = 1'b1;
    u_if.mbr_wr_b = 1'b1;
    step();
    idle();
    chk("mbr_prio", u_if.mem_d, 8'h11);

    // Reset between edges with a result pending
    load_ac(8'hF0);
    load_mbr(8'h20, 4'b0010);
    u_if.ula_re = 1'b1;
    step();
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_ac", u_if.ac_q, 8'h00);
    chk("midrst_mem_d", u_if.mem_d, 8'h00);
    chk("midrst_flags", {5'b0, u_if.flagz, u_if.flagn, u_if.flagc}, 8'h00);
    #1;
    reset = 1'b1;
    u_if.ula_re = 1'b1;
    u_if.ac_wr  = 1'b1;
    step();
    idle();
    chk("post_rst_ac", u_if.ac_q, 8'h00);
    chk("post_rst_flags", {5'b0, u_if.flagz, u_if.flagn, u_if.flagc}, 8'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
